// File: rtl/cpu_fetch_queue.sv
// Instruction fetch queue between the fetch stage and decode.
// Each instruction-bus response is stored with its fetch address. Decode
// receives the entries in order through a valid/ready handshake. A branch
// redirect (flush) empties the queue. It then ignores responses for
// FLUSH_SHADOW cycles, because those responses belong to the wrong path.
module cpu_fetch_queue #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_SHADOW = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] ibus_data,
  input  logic        ibus_valid,
  input  logic        flush,
  output logic        fetch_hold,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [7:0]  drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HOLD    = CW'(DEPTH - 1);
  localparam logic [2:0]    SHADOW_INIT = 3'(FLUSH_SHADOW);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [7:0]    drop_q,   drop_d;

  logic push_ok;
  logic pop;
  logic push;
  logic drop;

  // Handshake qualification. A flush overrides both the pop and the push in its cycle.
  always_comb begin
    push_ok = ibus_valid & ~flush & (shadow_q == 3'd0);
    pop     = id_valid & id_ready & ~flush;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    push    = push_ok & ((count_q != CNT_FULL) | pop);
    drop    = push_ok & (count_q == CNT_FULL) & ~pop;
  end

  // Next-state values for the pointers, the occupancy, the shadow timer and the drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    drop_d   = drop_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      shadow_d = SHADOW_INIT;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (shadow_q != 3'd0) shadow_d = shadow_q - 3'd1;
    end

    // The drop counter saturates so that a long overflow cannot wrap it to a small value.
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shadow_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage: {pc, inst} is written at the write pointer on an accepted push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {fetch_addr, ibus_data};
    end
  end

  // Outputs come from registered state only. There is no bypass from the instruction bus.
  always_comb begin
    id_pc      = mem_q[rd_ptr_q][63:32];
    id_inst    = mem_q[rd_ptr_q][31:0];
    id_valid   = (count_q != '0);
    fetch_hold = (count_q >= CNT_HOLD);
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed self-checking bench for cpu_fetch_queue with DEPTH=4 and FLUSH_SHADOW=1.
module tb_cpu_fetch_queue;

  logic        clock;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [31:0] ibus_data;
  logic        ibus_valid;
  logic        flush;
  logic        fetch_hold;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ready;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  cpu_fetch_queue #(.DEPTH(4), .FLUSH_SHADOW(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .fetch_addr (fetch_addr),
    .ibus_data  (ibus_data),
    .ibus_valid (ibus_valid),
    .flush      (flush),
    .fetch_hold (fetch_hold),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hdead_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle of stimulus, then samples the outputs 1 time unit after the clock edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic r, input logic f);
    ibus_valid = v;
    fetch_addr = a;
    ibus_data  = inst_of(a);
    id_ready   = r;
    flush      = f;
    tick();
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] drain_exp [4];
  int pushed;
  int popped;
  logic [4:0] rpat;
  logic [7:0] vpat;

  initial begin
    reset      = 1'b0;
    fetch_addr = '0;
    ibus_data  = '0;
    ibus_valid = 1'b0;
    flush      = 1'b0;
    id_ready   = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_hold", fetch_hold, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
    #2 reset = 1'b1;
    tick();

    // fill and drain
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'hbfc00000 + 32'(4 * i), 1'b0, 1'b0);
      chk("fill_valid", id_valid, 1'b1);
      chk("fill_pc", id_pc, 32'hbfc00000);
      chk("fill_hold", fetch_hold, (i >= 2) ? 1'b1 : 1'b0);
    end
    chk("fill_inst", id_inst, inst_of(32'hbfc00000));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_valid", id_valid, (i < 3) ? 1'b1 : 1'b0);
      if (i < 3) chk("drain_pc", id_pc, 32'hbfc00000 + 32'(4 * (i + 1)));
      chk("drain_hold", fetch_hold, (i == 0) ? 1'b1 : 1'b0);
    end

    // streaming: the head always holds the address pushed in the previous cycle
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      chk("stream_pc", id_pc, 32'h1000 + 32'(4 * i));
      chk("stream_hold", fetch_hold, 1'b0);
    end
    chk("stream_inst", id_inst, inst_of(32'h1000 + 32'(4 * 19)));
    chk("stream_drop", drop_count, 8'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_empty", id_valid, 1'b0);

    // overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    chk("ovf_drop", drop_count, 8'd3);
    chk("ovf_head", id_pc, 32'h2000);
    cyc(1'b1, 32'h4000, 1'b1, 1'b0);
    chk("ovf_pp_hold", fetch_hold, 1'b1);
    chk("ovf_pp_pc", id_pc, 32'h2004);
    chk("ovf_pp_drop", drop_count, 8'd3);
    drain_exp[0] = 32'h2004;
    drain_exp[1] = 32'h2008;
    drain_exp[2] = 32'h200c;
    drain_exp[3] = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order_valid", id_valid, 1'b1);
      chk("ovf_order_pc", id_pc, drain_exp[i]);
      chk("ovf_order_inst", id_inst, inst_of(drain_exp[i]));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("ovf_empty", id_valid, 1'b0);

    // flush with a one-cycle shadow
    cyc(1'b1, 32'h5000, 1'b0, 1'b0);
    cyc(1'b1, 32'h5004, 1'b0, 1'b0);
    chk("fl_pre_valid", id_valid, 1'b1);
    cyc(1'b1, 32'h6000, 1'b1, 1'b1);
    chk("fl_valid", id_valid, 1'b0);
    chk("fl_hold", fetch_hold, 1'b0);
    cyc(1'b1, 32'h6004, 1'b0, 1'b0);
    chk("fl_shadow_valid", id_valid, 1'b0);
    chk("fl_shadow_drop", drop_count, 8'd3);
    cyc(1'b1, 32'h6008, 1'b0, 1'b0);
    chk("fl_accept_valid", id_valid, 1'b1);
    chk("fl_accept_pc", id_pc, 32'h6008);

    // a second flush during the shadow period reloads the shadow timer
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h6100, 1'b0, 1'b0);
    chk("fl_reload_valid", id_valid, 1'b0);
    cyc(1'b1, 32'h6104, 1'b0, 1'b0);
    chk("fl_reload_pc", id_pc, 32'h6104);
    chk("fl_reload_drop", drop_count, 8'd3);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl_reload_empty", id_valid, 1'b0);

    // wrap-around with irregular push and pop rates
    pushed = 0;
    popped = 0;
    rpat   = 5'b10110;
    vpat   = 8'b11101101;
    exp_q.delete();
    for (int c = 0; c < 80 && popped < 10; c++) begin
      logic v;
      logic r;
      logic [31:0] a;
      r = rpat[c % 5];
      v = (pushed < 10) && vpat[c % 8] && (exp_q.size() < 4);
      a = 32'h7000 + 32'(4 * pushed);
      chk("wrap_valid", id_valid, (exp_q.size() != 0) ? 1'b1 : 1'b0);
      if (r && exp_q.size() != 0) begin
        chk("wrap_pc", id_pc, exp_q[0]);
        chk("wrap_inst", id_inst, inst_of(exp_q[0]));
        void'(exp_q.pop_front());
        popped++;
      end
      if (v) begin
        exp_q.push_back(a);
        pushed++;
      end
      cyc(v, a, r, 1'b0);
    end
    chk("wrap_done", 32'(popped), 32'd10);
    chk("wrap_drop", drop_count, 8'd3);

    // asynchronous reset while three entries are queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h8000 + 32'(4 * i), 1'b0, 1'b0);
    ibus_valid = 1'b0;
    chk("ar_pre_hold", fetch_hold, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", id_valid, 1'b0);
    chk("ar_hold", fetch_hold, 1'b0);
    chk("ar_drop", drop_count, 8'd0);
    chk("ar_pc", id_pc, 32'h0);
    #2 reset = 1'b1;
    cyc(1'b1, 32'h9000, 1'b0, 1'b0);
    chk("ar_push_valid", id_valid, 1'b1);
    chk("ar_push_pc", id_pc, 32'h9000);
    chk("ar_push_hold", fetch_hold, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_queue.md
# cpu_fetch_queue

Instruction fetch queue between the PC/fetch-request stage and decode. It captures each instruction returned on the instruction bus together with its fetch address. It buffers up to DEPTH entries and presents them in order to decode through a valid/ready handshake. On a branch redirect it discards buffered and in-flight wrong-path instructions, and it exerts back-pressure on the fetch stage when nearly full.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- FLUSH_SHADOW, 1, cycles after a flush during which returning responses are discarded (0..7).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_addr  in  32  address of the instruction returned this cycle.
- ibus_data  in  32  returned instruction word.
- ibus_valid  in  1  ibus_data/fetch_addr valid this cycle.
- flush  in  1  redirect taken; drop all queued and shadowed instructions.
- fetch_hold  out  1  back-pressure to fetch stage: count >= DEPTH-1.
- id_pc  out  32  PC of head entry.
- id_inst  out  32  instruction of head entry.
- id_valid  out  1  head entry valid (count != 0).
- id_ready  in  1  decode accepts head this cycle.
- drop_count  out  8  saturating count of responses lost to overflow.

## Operation
- State: DEPTH x 64-bit entry array {pc, inst}; wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH; count, log2(DEPTH)+1 bits; shadow counter, 3 bits; drop_count, 8 bits.
- Reset (reset low, asynchronous): pointers, count, shadow and drop_count = 0. All entries = 0. Outputs: id_valid 0, id_pc 0, id_inst 0, fetch_hold 0, drop_count 0.
- push_ok = ibus_valid & ~flush & (shadow == 0).
- pop = id_valid & id_ready & ~flush.
- Push: if push_ok and (count < DEPTH or pop), write {fetch_addr, ibus_data} at wr_ptr and increment wr_ptr.
- Overflow: if push_ok, count == DEPTH and ~pop, the response is dropped and drop_count increments, saturating at 255.
- Pop: increment rd_ptr.
- count' = count + push - pop.
- Simultaneous push and pop at full: both occur and count is unchanged.
- Simultaneous push and pop at empty: impossible, because id_valid = 0.
- Flush: at the next edge, rd_ptr = wr_ptr = count = 0 and shadow = FLUSH_SHADOW. The same-cycle response and pop are ignored. drop_count is unaffected.
- Shadow: while shadow != 0, decrement it once per cycle and discard ibus_valid responses without counting them as drops. A flush during the shadow period reloads shadow to FLUSH_SHADOW.
- Outputs:
  - id_pc and id_inst = entry[rd_ptr], driven from registers; no bypass from ibus.
  - id_valid = (count != 0).
  - fetch_hold = (count >= DEPTH-1).
  - All outputs are functions of registered state only.
- Head stability: id_pc and id_inst hold steady while id_valid & ~id_ready.

## Timing
- Push-to-decode latency: 1 cycle. A response accepted at edge N is visible at id_* after edge N, for an empty queue.
- Pop: decode sees the next entry in the cycle after the accepting edge.
- Throughput: 1 push and 1 pop per cycle sustained.
- Flush: id_valid = 0 in the cycle after the flush edge. The first post-flush response can be accepted FLUSH_SHADOW cycles after the flush edge.
- fetch_hold: asserts in the cycle after count reaches DEPTH-1. The fetch stage has one in-flight response, so one slot of margin remains.
- Mid-operation reset: asynchronous clear. State is exactly the reset state on the first edge after reset deasserts.

## Test plan
- Fill and drain, DEPTH=4: push pc 0xbfc00000..0xbfc0000c with id_ready=0. Expected: fetch_hold rises after the 3rd push; id_pc=0xbfc00000 holds. Then id_ready=1 pops the entries in order over 4 cycles, and id_valid falls after the 4th.
- Streaming: ibus_valid=1 and id_ready=1 every cycle for 20 cycles. Expected: count stays 1; id_pc trails fetch_addr by exactly 1 cycle; no drops.
- Overflow: fill to 4 with id_ready=0, then push 3 more. Expected: drop_count=3, queue contents unchanged. Then push with a simultaneous pop at full: accepted, count stays 4, drop_count stays 3.
- Flush with shadow, FLUSH_SHADOW=1: queue holds 2 entries; assert flush together with ibus_valid. Expected: next cycle id_valid=0 and the response on the following cycle is discarded with drop_count unchanged. The response two cycles after flush is accepted and appears at id_pc.
- Wrap-around: push and pop 10 entries interleaved at varying rates. Expected: pointers wrap past DEPTH-1 and FIFO order is preserved for all 10 PCs.
- Async reset mid-operation: pull reset low between edges with 3 entries queued. Expected: id_valid, fetch_hold and drop_count go to 0 immediately; after release, the first push appears 1 cycle later.
